// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU.
// Opcode and FSM encodings live here so core, ALU and bench agree.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 16;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_LOAD  = 4'h1,
      OP_STORE = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_AND   = 4'h5,
      OP_OR    = 4'h6,
      OP_XOR   = 4'h7,
      OP_NOT   = 4'h8,
      OP_LDI   = 4'h9,
      OP_JMP   = 4'hA,
      OP_JZ    = 4'hB,
      OP_JN    = 4'hC,
      OP_SHL   = 4'hD,
      OP_SHR   = 4'hE,
      OP_HALT  = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Only opcode and operand are architecturally visible; [27:16] is dropped.
   typedef struct packed {
      opcode_t           op;
      logic [ADDR_W-1:0] arg;
   } ir_t;

   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
      return {{(DATA_W-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Accumulator datapath: computes the next AC value for any opcode.
// Non-AC opcodes return the AC unchanged.
module cpu_alu
   import cpu_pkg::*;
(
   input  opcode_t           op,
   input  logic [DATA_W-1:0] ac,
   input  logic [DATA_W-1:0] mbr_r,
   input  logic [15:0]       imm16,
   output logic [DATA_W-1:0] res
);

   always_comb begin
      res = ac;
      unique case (op)
         OP_LOAD: res = mbr_r;
         OP_ADD:  res = ac + mbr_r;
         OP_SUB:  res = ac - mbr_r;
         OP_AND:  res = ac & mbr_r;
         OP_OR:   res = ac | mbr_r;
         OP_XOR:  res = ac ^ mbr_r;
         OP_NOT:  res = ~ac;
         OP_LDI:  res = sext16(imm16);
         OP_SHL:  res = {ac[DATA_W-2:0], 1'b0};
         OP_SHR:  res = {1'b0, ac[DATA_W-1:1]};
         default: res = ac;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// Two-cycle accumulator CPU: FETCH loads IR, EXEC runs it.
// Memory reads are combinational, so each phase needs one cycle.
module cpu_core
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] MAR,
   input  logic [DATA_W-1:0] MBR_R,
   output logic [DATA_W-1:0] MBR_W,
   output logic              write
);

   localparam logic [1:0] S_FETCH = ST_FETCH;
   localparam logic [1:0] S_EXEC  = ST_EXEC;
   localparam logic [1:0] S_HALT  = ST_HALT;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   ir_t               ir_q, ir_d;
   logic [DATA_W-1:0] ac_q, ac_d;

   logic [DATA_W-1:0] alu_res;
   logic              take;
   logic              in_exec;

   cpu_alu u_alu (
      .op    (ir_q.op),
      .ac    (ac_q),
      .mbr_r (MBR_R),
      .imm16 (ir_q.arg),
      .res   (alu_res)
   );

   assign in_exec = (state_q == S_EXEC);

   always_comb begin
      take = 1'b0;
      unique case (1'b1)
         (ir_q.op == OP_JMP): take = 1'b1;
         (ir_q.op == OP_JZ):  take = (ac_q == '0);
         (ir_q.op == OP_JN):  take = ac_q[DATA_W-1];
         default:             take = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ac_d    = ac_q;
      unique case (state_q)
         S_FETCH: begin
            ir_d.op  = opcode_t'(MBR_R[31:28]);
            ir_d.arg = MBR_R[ADDR_W-1:0];
            pc_d     = pc_q + 16'd1;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            ac_d = alu_res;
            if (take) pc_d = ir_q.arg;
            state_d = (ir_q.op == OP_HALT) ? S_HALT : S_FETCH;
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         ac_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
      end
   end

   // Bus muxing is purely from state, so async reset clears write at once.
   assign MAR   = in_exec ? ir_q.arg : pc_q;
   assign write = in_exec && (ir_q.op == OP_STORE);
   assign MBR_W = ac_q;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core with a behavioural 64Kx32 memory.
// Expected stores go through a scoreboard checked on every write pulse.
module tb_cpu_core;
   import cpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] mar;
   logic [31:0] mbr_r;
   logic [31:0] mbr_w;
   logic        wr;

   logic [31:0] mem [0:65535];
   logic [47:0] sb [$];
   logic [15:0] trace [0:21];

   int n_chk;
   int n_err;
   int wr_cnt;

   cpu_core dut (
      .clk   (clk),
      .reset (rst_n),
      .MAR   (mar),
      .MBR_R (mbr_r),
      .MBR_W (mbr_w),
      .write (wr)
   );

   assign mbr_r = mem[mar];

   always @(posedge clk) begin
      if (wr) mem[mar] <= mbr_w;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input opcode_t op,
                                       input logic [15:0] a);
      return {op, 12'h5A5, a};
   endfunction

   always @(negedge clk) begin
      logic [47:0] e;
      if (rst_n && wr) begin
         wr_cnt++;
         if (sb.size() == 0) begin
            chk("sb_extra", 32'(wr), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_addr", 32'(mar), 32'(e[47:32]));
            chk("sb_data", mbr_w, e[31:0]);
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      sb.delete();
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
      sb.push_back({a, d});
   endtask

   task automatic hold_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      wr_cnt = 0;
      repeat (3) @(negedge clk);
      chk({tag, "_rst_mar"}, 32'(mar), 32'h0);
      chk({tag, "_rst_wr"}, 32'(wr), 32'h0);
      chk({tag, "_rst_ac"}, mbr_w, 32'h0);
   endtask

   task automatic release_run(input int n);
      rst_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic finish_test(input string tag, input int wr_exp,
                              input logic [15:0] mar_exp);
      chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(wr_exp));
      chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
      chk({tag, "_halt_mar"}, 32'(mar), 32'(mar_exp));
      chk({tag, "_halt_wr"}, 32'(wr), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      n_chk  = 0;
      n_err  = 0;
      wr_cnt = 0;

      // load / add / store, with the first MAR steps after release
      clear_mem();
      mem[0]  = enc(OP_LOAD, 16'd10);
      mem[1]  = enc(OP_ADD, 16'd11);
      mem[2]  = enc(OP_STORE, 16'd12);
      mem[3]  = enc(OP_HALT, 16'd0);
      mem[10] = 32'd5;
      mem[11] = 32'd7;
      expect_wr(16'd12, 32'd12);
      hold_reset("las");
      rst_n = 1'b1;
      #1 chk("las_mar0", 32'(mar), 32'h0000);
      @(negedge clk);
      chk("las_mar1", 32'(mar), 32'h000A);
      @(negedge clk);
      chk("las_mar2", 32'(mar), 32'h0001);
      repeat (8) @(negedge clk);
      chk("las_mem12", mem[12], 32'd12);
      finish_test("las", 1, 16'h0004);

      // immediate and logic ops
      clear_mem();
      mem[0]  = enc(OP_LDI, 16'hFFFF);
      mem[1]  = enc(OP_STORE, 16'h0040);
      mem[2]  = enc(OP_SHR, 16'h0000);
      mem[3]  = enc(OP_STORE, 16'h0041);
      mem[4]  = enc(OP_NOT, 16'h0000);
      mem[5]  = enc(OP_STORE, 16'h0042);
      mem[6]  = enc(OP_SHL, 16'h0000);
      mem[7]  = enc(OP_STORE, 16'h0043);
      mem[8]  = enc(OP_NOT, 16'h0000);
      mem[9]  = enc(OP_STORE, 16'h0044);
      mem[10] = enc(OP_LDI, 16'h7FFF);
      mem[11] = enc(OP_STORE, 16'h0045);
      mem[12] = enc(OP_HALT, 16'h0000);
      expect_wr(16'h0040, 32'hFFFF_FFFF);
      expect_wr(16'h0041, 32'h7FFF_FFFF);
      expect_wr(16'h0042, 32'h8000_0000);
      expect_wr(16'h0043, 32'h0000_0000);
      expect_wr(16'h0044, 32'hFFFF_FFFF);
      expect_wr(16'h0045, 32'h0000_7FFF);
      hold_reset("imm");
      release_run(30);
      chk("imm_ac", mbr_w, 32'h0000_7FFF);
      finish_test("imm", 6, 16'h000D);

      // arithmetic wrap and bitwise ops
      clear_mem();
      mem[0]  = enc(OP_LOAD, 16'h0060);
      mem[1]  = enc(OP_ADD, 16'h0061);
      mem[2]  = enc(OP_STORE, 16'h0062);
      mem[3]  = enc(OP_SUB, 16'h0063);
      mem[4]  = enc(OP_STORE, 16'h0064);
      mem[5]  = enc(OP_LOAD, 16'h0060);
      mem[6]  = enc(OP_XOR, 16'h0061);
      mem[7]  = enc(OP_STORE, 16'h0067);
      mem[8]  = enc(OP_OR, 16'h0061);
      mem[9]  = enc(OP_AND, 16'h0065);
      mem[10] = enc(OP_STORE, 16'h0066);
      mem[11] = enc(OP_HALT, 16'h0000);
      mem[16'h60] = 32'h7FFF_FFFF;
      mem[16'h61] = 32'h0000_0001;
      mem[16'h63] = 32'h8000_0001;
      mem[16'h65] = 32'h0F0F_0F0F;
      expect_wr(16'h0062, 32'h8000_0000);
      expect_wr(16'h0064, 32'hFFFF_FFFF);
      expect_wr(16'h0067, 32'h7FFF_FFFE);
      expect_wr(16'h0066, 32'h0F0F_0F0F);
      hold_reset("alu");
      release_run(30);
      finish_test("alu", 4, 16'h000C);

      // branches: taken JZ, untaken JZ, taken JN
      clear_mem();
      mem[16'h00] = enc(OP_LDI, 16'h0000);
      mem[16'h01] = enc(OP_JZ, 16'h0020);
      mem[16'h02] = enc(OP_LDI, 16'h0BAD);
      mem[16'h03] = enc(OP_STORE, 16'h0050);
      mem[16'h04] = enc(OP_HALT, 16'h0000);
      mem[16'h20] = enc(OP_LDI, 16'h0001);
      mem[16'h21] = enc(OP_JZ, 16'h0030);
      mem[16'h22] = enc(OP_STORE, 16'h0041);
      mem[16'h23] = enc(OP_LDI, 16'h8000);
      mem[16'h24] = enc(OP_JN, 16'h0030);
      mem[16'h25] = enc(OP_STORE, 16'h0042);
      mem[16'h26] = enc(OP_HALT, 16'h0000);
      mem[16'h30] = enc(OP_STORE, 16'h0043);
      mem[16'h31] = enc(OP_HALT, 16'h0000);
      expect_wr(16'h0041, 32'h0000_0001);
      expect_wr(16'h0043, 32'hFFFF_8000);
      hold_reset("br");
      release_run(30);
      finish_test("br", 2, 16'h0032);

      // PC wrap through FFFF, with the stored flag steering the second pass
      clear_mem();
      mem[16'h0000] = enc(OP_LOAD, 16'h0046);
      mem[16'h0001] = enc(OP_JN, 16'h0028);
      mem[16'h0002] = enc(OP_LDI, 16'h8000);
      mem[16'h0003] = enc(OP_STORE, 16'h0046);
      mem[16'h0004] = enc(OP_JMP, 16'hFFFF);
      mem[16'hFFFF] = enc(OP_NOP, 16'h1234);
      mem[16'h0028] = enc(OP_STORE, 16'h0047);
      mem[16'h0029] = enc(OP_HALT, 16'h0000);
      expect_wr(16'h0046, 32'hFFFF_8000);
      expect_wr(16'h0047, 32'hFFFF_8000);
      trace = '{16'h0000, 16'h0046, 16'h0001, 16'h0028, 16'h0002,
                16'h8000, 16'h0003, 16'h0046, 16'h0004, 16'hFFFF,
                16'hFFFF, 16'h1234, 16'h0000, 16'h0046, 16'h0001,
                16'h0028, 16'h0028, 16'h0047, 16'h0029, 16'h0000,
                16'h002A, 16'h002A};
      hold_reset("wrap");
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 22; i++) begin
         chk($sformatf("wrap_mar%0d", i), 32'(mar), 32'(trace[i]));
         @(negedge clk);
      end
      chk("wrap_mem47", mem[16'h47], 32'hFFFF_8000);
      finish_test("wrap", 2, 16'h002A);

      // async reset during a STORE's EXEC cycle
      clear_mem();
      mem[0] = enc(OP_LDI, 16'h1234);
      mem[1] = enc(OP_STORE, 16'h0080);
      mem[2] = enc(OP_HALT, 16'h0000);
      mem[16'h80] = 32'hDEAD_BEEF;
      hold_reset("mid");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("mid_wr_pre", 32'(wr), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_wr_drop", 32'(wr), 32'd0);
      chk("mid_mar", 32'(mar), 32'h0000);
      chk("mid_ac", mbr_w, 32'h0);
      repeat (2) @(negedge clk);
      chk("mid_mem80", mem[16'h80], 32'hDEAD_BEEF);
      chk("mid_wrcnt", 32'(wr_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
